// File: rtl/seg_disp_pkg.sv
// Shared constants for the seven-segment display scheduler: glyphs, anode
// patterns, FSM encodings and the 4-digit BCD limit.
package seg_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [3:0] AN_D3  = 4'b0111;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_OFF = 4'b1111;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [15:0] BCD_MAX = 16'd9999;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_scheduler_bin2bcd_seq.sv
// Sequential double-dabble converter: 16 shift cycles after start, done marks
// the final shift so the caller can commit on the following cycle.
module bin2bcd_seq
    import seg_disp_pkg::*;
(
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin_in,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf
);

    logic [15:0] shreg;
    logic [15:0] bcd_adj;
    logic [3:0]  cnt;
    logic        busy;

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign done = busy && (cnt == 4'd15);

    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            bcd   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            shreg <= bin_in;
            bcd   <= '0;
            ovf   <= (bin_in > BCD_MAX);
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            bcd   <= {bcd_adj[14:0], shreg[15]};
            shreg <= {shreg[14:0], 1'b0};
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd15)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Shares the 4-digit multiplexed display between NUM_SRC 16-bit sources,
// converting the selected value to BCD continuously (18-cycle loop).
module seg_display_scheduler
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned SEL_W        = 2,
    parameter int unsigned DWELL_CYCLES = 100000000,
    parameter int unsigned SCAN_MSB     = 19,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic                   clk_100mhz,
    input  logic                   reset,
    input  logic [NUM_SRC*16-1:0]  src_data,
    input  logic                   mode_auto,
    input  logic [SEL_W-1:0]       manual_sel,
    output logic [3:0]             Anode_Activate,
    output logic [6:0]             LED_out,
    output logic                   dp_out,
    output logic [SEL_W-1:0]       cur_src,
    output logic                   conv_busy
);

    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    logic [1:0]         state, state_nx;
    logic [SEL_W-1:0]   sel_nx, sel_q, rot_idx;
    logic [DW-1:0]      dwell_cnt;
    logic [15:0]        load_val, eng_bcd, disp_bcd;
    logic               eng_done, eng_ovf, disp_ovf;
    logic [SCAN_MSB:0]  refresh_counter;
    logic [1:0]         digit;
    logic [3:0]         an_nx, dig;
    logic [6:0]         seg_nx;
    logic               dp_nx, lead_zero;

    bin2bcd_seq u_bin2bcd (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .start      (state == ST_LOAD),
        .bin_in     (load_val),
        .done       (eng_done),
        .bcd        (eng_bcd),
        .ovf        (eng_ovf)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_LOAD:   state_nx = ST_SHIFT;
            ST_SHIFT:  if (eng_done) state_nx = ST_COMMIT;
            ST_COMMIT: state_nx = ST_LOAD;
            default:   state_nx = ST_LOAD;
        endcase
    end

    // Out-of-range manual selections fall back to source 0.
    always_comb begin
        if (mode_auto)
            sel_nx = rot_idx;
        else if (32'(manual_sel) >= NUM_SRC)
            sel_nx = '0;
        else
            sel_nx = manual_sel;
        load_val = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (32'(sel_nx) == i)
                load_val = src_data[16*i +: 16];
        end
    end

    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            state     <= ST_LOAD;
            sel_q     <= '0;
            cur_src   <= '0;
            disp_bcd  <= '0;
            disp_ovf  <= 1'b0;
            conv_busy <= 1'b0;
        end else begin
            state     <= state_nx;
            conv_busy <= (state_nx != ST_COMMIT);
            if (state == ST_LOAD)
                sel_q <= sel_nx;
            if (state == ST_COMMIT) begin
                disp_bcd <= eng_bcd;
                disp_ovf <= eng_ovf;
                cur_src  <= sel_q;
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            dwell_cnt <= '0;
            rot_idx   <= '0;
        end else if (!mode_auto) begin
            dwell_cnt <= '0;
            rot_idx   <= '0;
        end else if (dwell_cnt == DW'(DWELL_CYCLES - 1)) begin
            dwell_cnt <= '0;
            rot_idx   <= (rot_idx == SEL_W'(NUM_SRC - 1)) ? '0 : rot_idx + 1'b1;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    assign digit = refresh_counter[SCAN_MSB -: 2];

    always_comb begin
        case (digit)
            2'd0: begin an_nx = AN_D3; dig = disp_bcd[15:12]; lead_zero = (disp_bcd[15:12] == '0); end
            2'd1: begin an_nx = AN_D2; dig = disp_bcd[11:8];  lead_zero = (disp_bcd[15:8]  == '0); end
            2'd2: begin an_nx = AN_D1; dig = disp_bcd[7:4];   lead_zero = (disp_bcd[15:4]  == '0); end
            default: begin an_nx = AN_D0; dig = disp_bcd[3:0]; lead_zero = 1'b0; end
        endcase
        if (disp_ovf)
            seg_nx = SEG_DASH;
        else if (BLANK_LZ && lead_zero)
            seg_nx = SEG_BLANK;
        else
            seg_nx = seg_encode(dig);
        dp_nx = (32'(cur_src) != 32'(digit));
    end

    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            refresh_counter <= '0;
            Anode_Activate  <= AN_OFF;
            LED_out         <= SEG_BLANK;
            dp_out          <= 1'b1;
        end else begin
            refresh_counter <= refresh_counter + 1'b1;
            Anode_Activate  <= an_nx;
            LED_out         <= seg_nx;
            dp_out          <= dp_nx;
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler: scan, conversion, blanking,
// overflow, rotation, mode change and mid-conversion reset.
module tb_seg_display_scheduler;

    localparam int unsigned NSRC = 4;

    logic        clk_100mhz = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] src_data = '0;
    logic        mode_auto = 1'b0;
    logic [2:0]  manual_sel = '0;
    logic [3:0]  Anode_Activate;
    logic [6:0]  LED_out;
    logic        dp_out;
    logic [2:0]  cur_src;
    logic        conv_busy;

    int unsigned cyc;
    int          checks = 0;
    int          passed = 0;

    seg_display_scheduler #(
        .NUM_SRC      (4),
        .SEL_W        (3),
        .DWELL_CYCLES (64),
        .SCAN_MSB     (3),
        .BLANK_LZ     (1'b1)
    ) dut (
        .clk_100mhz     (clk_100mhz),
        .reset          (reset),
        .src_data       (src_data),
        .mode_auto      (mode_auto),
        .manual_sel     (manual_sel),
        .Anode_Activate (Anode_Activate),
        .LED_out        (LED_out),
        .dp_out         (dp_out),
        .cur_src        (cur_src),
        .conv_busy      (conv_busy)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Clock edges seen since reset was released.
    always @(posedge clk_100mhz or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] digit_glyph(int unsigned d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  default: return 7'b0000100;
        endcase
    endfunction

    // pos 0 = thousands ... 3 = units
    function automatic logic [6:0] model_seg(int unsigned v, int unsigned pos);
        int unsigned place;
        case (pos)
            0: place = 1000;
            1: place = 100;
            2: place = 10;
            default: place = 1;
        endcase
        if (v > 9999) return 7'b1111110;
        if (pos != 3 && v < place) return 7'b1111111;
        return digit_glyph((v / place) % 10);
    endfunction

    function automatic int unsigned model_pos(int unsigned k);
        return ((k - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] model_anode(int unsigned pos);
        logic [3:0] one_hot;
        one_hot = 4'b1000 >> pos;
        return ~one_hot;
    endfunction

    // Auto mode from reset release: rotation index after edge k is (k/64)%4,
    // sampled at loads 18m+1 and shown from commit 18(m+1).
    function automatic int unsigned model_auto_cur(int unsigned k);
        int unsigned m;
        m = k / 18;
        if (m == 0) return 0;
        return ((18 * (m - 1)) / 64) % 4;
    endfunction

    task automatic do_reset(input logic auto_m, input logic [2:0] sel, input logic [63:0] data);
        @(negedge clk_100mhz);
        reset = 1'b0;
        mode_auto = auto_m;
        manual_sel = sel;
        src_data = data;
        repeat (3) @(negedge clk_100mhz);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_100mhz);
        reset = 1'b0;
        mode_auto = 1'b0;
        manual_sel = 3'd1;
        src_data = {16'd0, 16'd0, 16'd1234, 16'd0};
        #1;
        checks++; if (Anode_Activate !== 4'b1111) $display("FAIL reset_anode: got %b expected 1111", Anode_Activate); else passed++;
        checks++; if (LED_out !== 7'b1111111) $display("FAIL reset_led: got %b expected 1111111", LED_out); else passed++;
        checks++; if (dp_out !== 1'b1) $display("FAIL reset_dp: got %b expected 1", dp_out); else passed++;
        checks++; if (cur_src !== 3'd0) $display("FAIL reset_cur_src: got %0d expected 0", cur_src); else passed++;
        checks++; if (conv_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", conv_busy); else passed++;
        repeat (2) @(negedge clk_100mhz);
        reset = 1'b1;
        for (int n = 0; n < 19; n++) begin
            @(negedge clk_100mhz);
            checks++;
            if (cur_src !== ((cyc < 18) ? 3'd0 : 3'd1))
                $display("FAIL first_commit_cur_src: cycle %0d got %0d expected %0d", cyc, cur_src, (cyc < 18) ? 0 : 1);
            else passed++;
            checks++;
            if (conv_busy !== ((cyc % 18) != 17))
                $display("FAIL conv_busy: cycle %0d got %b expected %b", cyc, conv_busy, (cyc % 18) != 17);
            else passed++;
        end
    endtask

    task automatic test_conversion();
        int unsigned pos;
        do_reset(1'b0, 3'd1, {16'd0, 16'd0, 16'd1234, 16'd0});
        while (cyc < 18) @(negedge clk_100mhz);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk_100mhz);
            pos = model_pos(cyc);
            checks++; if (Anode_Activate !== model_anode(pos)) $display("FAIL conv_anode: cycle %0d got %b expected %b", cyc, Anode_Activate, model_anode(pos)); else passed++;
            checks++; if (LED_out !== model_seg(1234, pos)) $display("FAIL conv_led: pos %0d got %b expected %b", pos, LED_out, model_seg(1234, pos)); else passed++;
            checks++; if (dp_out !== (pos != 1)) $display("FAIL conv_dp: pos %0d got %b expected %b", pos, dp_out, pos != 1); else passed++;
        end
    endtask

    task automatic test_values();
        int unsigned dir [6] = '{7, 10000, 0, 9999, 10, 65535};
        int unsigned vals [NSRC];
        int unsigned sel, esel, v, pos;
        do_reset(1'b0, 3'd0, '0);
        for (int n = 0; n < 26; n++) begin
            @(negedge clk_100mhz);
            for (int unsigned i = 0; i < NSRC; i++) begin
                case ($urandom_range(0, 3))
                    0: vals[i] = $urandom_range(0, 9);
                    1: vals[i] = $urandom_range(10, 9999);
                    2: vals[i] = $urandom_range(10000, 65535);
                    default: vals[i] = $urandom_range(9999, 10000);
                endcase
            end
            if (n < 6) begin
                sel = 0;
                vals[0] = dir[n];
            end else begin
                sel = $urandom_range(0, 7);
            end
            for (int unsigned i = 0; i < NSRC; i++) src_data[16*i +: 16] = 16'(vals[i]);
            manual_sel = 3'(sel);
            esel = (sel < NSRC) ? sel : 0;
            v = vals[esel];
            repeat (40) @(negedge clk_100mhz);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk_100mhz);
                pos = model_pos(cyc);
                checks++; if (Anode_Activate !== model_anode(pos)) $display("FAIL val_anode: cycle %0d got %b expected %b", cyc, Anode_Activate, model_anode(pos)); else passed++;
                checks++; if (LED_out !== model_seg(v, pos)) $display("FAIL val_led: value %0d pos %0d got %b expected %b", v, pos, LED_out, model_seg(v, pos)); else passed++;
                checks++; if (dp_out !== (pos != esel)) $display("FAIL val_dp: sel %0d pos %0d got %b expected %b", sel, pos, dp_out, pos != esel); else passed++;
                checks++; if (cur_src !== 3'(esel)) $display("FAIL val_cur_src: sel %0d got %0d expected %0d", sel, cur_src, esel); else passed++;
            end
        end
    endtask

    task automatic test_auto_rotation();
        int unsigned vals [NSRC] = '{11, 22, 33, 44};
        int unsigned pos, ecur, pcur, ev;
        do_reset(1'b1, 3'd0, {16'd44, 16'd33, 16'd22, 16'd11});
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_100mhz);
            ecur = model_auto_cur(cyc);
            checks++; if (cur_src !== 3'(ecur)) $display("FAIL auto_cur_src: cycle %0d got %0d expected %0d", cyc, cur_src, ecur); else passed++;
            pos = model_pos(cyc);
            pcur = model_auto_cur(cyc - 1);
            ev = (cyc - 1 < 18) ? 0 : vals[pcur];
            checks++; if (LED_out !== model_seg(ev, pos)) $display("FAIL auto_led: cycle %0d got %b expected %b", cyc, LED_out, model_seg(ev, pos)); else passed++;
            checks++; if (dp_out !== (pos != pcur)) $display("FAIL auto_dp: cycle %0d got %b expected %b", cyc, dp_out, pos != pcur); else passed++;
        end
    endtask

    task automatic test_mode_change();
        int unsigned pos, ecur;
        do_reset(1'b1, 3'd5, {16'd10001, 16'd3, 16'd2000, 16'd100});
        for (int g = 0; g < 200 && cyc < 80; g++) @(negedge clk_100mhz);
        mode_auto = 1'b0;
        while (cyc < 125) begin
            @(negedge clk_100mhz);
            ecur = (cyc < 90) ? 0 : (cyc < 108) ? 1 : 0;
            checks++; if (cur_src !== 3'(ecur)) $display("FAIL mode_cur_src: cycle %0d got %0d expected %0d", cyc, cur_src, ecur); else passed++;
            if (cyc >= 109) begin
                pos = model_pos(cyc);
                checks++; if (LED_out !== model_seg(100, pos)) $display("FAIL mode_led: cycle %0d got %b expected %b", cyc, LED_out, model_seg(100, pos)); else passed++;
            end
        end
    endtask

    task automatic test_mid_reset();
        int unsigned pos, pcur, ev;
        do_reset(1'b0, 3'd2, {16'd0, 16'd1234, 16'd0, 16'd0});
        for (int g = 0; g < 200 && cyc < 40; g++) @(negedge clk_100mhz);
        src_data[47:32] = 16'd9999;
        for (int g = 0; g < 200 && cyc < 63; g++) @(negedge clk_100mhz);
        reset = 1'b0;
        #1;
        checks++; if (Anode_Activate !== 4'b1111) $display("FAIL midrst_anode: got %b expected 1111", Anode_Activate); else passed++;
        checks++; if (LED_out !== 7'b1111111) $display("FAIL midrst_led: got %b expected 1111111", LED_out); else passed++;
        checks++; if (dp_out !== 1'b1) $display("FAIL midrst_dp: got %b expected 1", dp_out); else passed++;
        checks++; if (cur_src !== 3'd0) $display("FAIL midrst_cur_src: got %0d expected 0", cur_src); else passed++;
        repeat (2) @(negedge clk_100mhz);
        reset = 1'b1;
        for (int n = 0; n < 36; n++) begin
            @(negedge clk_100mhz);
            pos = model_pos(cyc);
            pcur = (cyc - 1 < 18) ? 0 : 2;
            ev = (cyc - 1 < 18) ? 0 : 9999;
            checks++; if (Anode_Activate !== model_anode(pos)) $display("FAIL midrst_scan: cycle %0d got %b expected %b", cyc, Anode_Activate, model_anode(pos)); else passed++;
            checks++; if (LED_out !== model_seg(ev, pos)) $display("FAIL midrst_value: cycle %0d got %b expected %b", cyc, LED_out, model_seg(ev, pos)); else passed++;
            checks++; if (dp_out !== (pos != pcur)) $display("FAIL midrst_dp_scan: cycle %0d got %b expected %b", cyc, dp_out, pos != pcur); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_values();
        test_auto_rotation();
        test_mode_change();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
